// File: rtl/rr_stream_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Holds the arbitration state encoding and the modular index increment.
package rr_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int unsigned IDX_MAX_W = 4;

  // Wraps explicitly at n-1 so non-power-of-2 requester counts rotate correctly.
  function automatic logic [IDX_MAX_W-1:0] next_idx(input logic [IDX_MAX_W-1:0] idx,
                                                    input logic [IDX_MAX_W:0]   n);
    logic [IDX_MAX_W:0] nxt_s;
    nxt_s = {1'b0, idx} + {{IDX_MAX_W{1'b0}}, 1'b1};
    if (nxt_s >= n) begin
      return {IDX_MAX_W{1'b0}};
    end else begin
      return nxt_s[IDX_MAX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/rr_stream_arbiter_if.sv
// Requester-side and output-side handshake bundle of the round-robin arbiter.
interface rr_stream_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(N)
);
  logic [N-1:0]       valid_in_i;
  logic [N-1:0]       ready_in_o;
  logic [N*WIDTH-1:0] data_in_i;
  logic [N-1:0]       last_in_i;
  logic               valid_out_o;
  logic               ready_out_i;
  logic [WIDTH-1:0]   data_out_o;
  logic               last_out_o;
  logic [IDW-1:0]     id_out_o;

  modport slave (
    input  valid_in_i, data_in_i, last_in_i, ready_out_i,
    output ready_in_o, valid_out_o, data_out_o, last_out_o, id_out_o
  );

  modport master (
    output valid_in_i, data_in_i, last_in_i, ready_out_i,
    input  ready_in_o, valid_out_o, data_out_o, last_out_o, id_out_o
  );
endinterface

// File: rtl/rr_stream_arbiter_pick.sv
// Combinational rotate-priority encoder: first asserted request at or above ptr, wrapping mod N.
module rr_priority_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);

  // Search from ptr upward; the candidate index never exceeds 2N-2 before the wrap.
  always_comb begin
    logic [IDW:0] cand_s;
    gnt_idx = '0;
    any     = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < N; i++) begin
      cand_s = {1'b0, ptr} + (IDW+1)'(i);
      if (cand_s >= (IDW+1)'(N)) begin
        cand_s = cand_s - (IDW+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!any && req[cand_s[IDW-1:0]]) begin
        any     = 1'b1;
        gnt_idx = cand_s[IDW-1:0];
      end else begin
        any     = any;
      end
    end
  end

  // One-hot view of the winning index.
  always_comb begin
    if (any) begin
      gnt = {{(N-1){1'b0}}, 1'b1} << gnt_idx;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin packet arbiter feeding one registered valid/ready output stage.
// A winner keeps the grant until its last beat transfers; ready_in_o is combinational on ready_out_i.
module rr_stream_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(N)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rr_stream_arbiter_if.slave  bus
);

  arb_state_t       state_r;
  logic [IDW-1:0]   rr_ptr_r;
  logic [IDW-1:0]   lock_id_r;
  logic             full_r;
  logic [WIDTH-1:0] data_r;
  logic             last_r;
  logic [IDW-1:0]   id_r;

  logic [N-1:0]     pick_gnt_s;
  logic [IDW-1:0]   pick_idx_s;
  logic             pick_any_s;
  logic             can_accept_s;
  logic [N-1:0]     ready_in_s;
  logic             in_xfer_s;
  logic [IDW-1:0]   xfer_idx_s;
  logic             xfer_last_s;
  logic [WIDTH-1:0] xfer_data_s;

  rr_priority_pick #(.N(N), .IDW(IDW)) u_pick (
    .req     (bus.valid_in_i),
    .ptr     (rr_ptr_r),
    .gnt     (pick_gnt_s),
    .gnt_idx (pick_idx_s),
    .any     (pick_any_s)
  );

  assign can_accept_s = !full_r || bus.ready_out_i;

  // Grant: the locked requester alone while in a packet, otherwise the round-robin winner.
  always_comb begin
    ready_in_s = '0;
    if (rst_i) begin
      ready_in_s = '0;
    end else if (state_r == LOCK) begin
      ready_in_s[lock_id_r] = can_accept_s;
    end else if (pick_any_s) begin
      ready_in_s = pick_gnt_s & {N{can_accept_s}};
    end else begin
      ready_in_s = '0;
    end
  end

  // Index and payload of the requester that may transfer this cycle.
  always_comb begin
    xfer_data_s = '0;
    if (state_r == LOCK) begin
      xfer_idx_s = lock_id_r;
    end else begin
      xfer_idx_s = pick_idx_s;
    end
    for (int k = 0; k < N; k++) begin
      if (IDW'(k) == xfer_idx_s) begin
        xfer_data_s = bus.data_in_i[k*WIDTH +: WIDTH];
      end else begin
        xfer_data_s = xfer_data_s;
      end
    end
  end

  assign xfer_last_s = bus.last_in_i[xfer_idx_s];
  assign in_xfer_s   = |(bus.valid_in_i & ready_in_s);

  // Arbitration FSM, rotation pointer, packet lock and output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= ARB;
      rr_ptr_r  <= '0;
      lock_id_r <= '0;
      full_r    <= 1'b0;
      data_r    <= '0;
      last_r    <= 1'b0;
      id_r      <= '0;
    end else if (in_xfer_s) begin
      full_r <= 1'b1;
      data_r <= xfer_data_s;
      last_r <= xfer_last_s;
      id_r   <= xfer_idx_s;
      if (xfer_last_s) begin
        state_r  <= ARB;
        rr_ptr_r <= IDW'(next_idx(IDX_MAX_W'(xfer_idx_s), (IDX_MAX_W+1)'(N)));
      end else begin
        state_r   <= LOCK;
        lock_id_r <= xfer_idx_s;
      end
    end else if (bus.ready_out_i) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  assign bus.ready_in_o  = ready_in_s;
  assign bus.valid_out_o = full_r;
  assign bus.data_out_o  = data_r;
  assign bus.last_out_o  = last_r;
  assign bus.id_out_o    = id_r;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter: N=4 instance for most scenarios, N=3 for the wrap case.
module tb_rr_stream_arbiter;

  logic clk;
  logic rst;
  int   cmp_cnt;
  int   err_cnt;

  rr_stream_arbiter_if #(.N(4), .WIDTH(32)) ifc4 ();
  rr_stream_arbiter_if #(.N(3), .WIDTH(32)) ifc3 ();

  rr_stream_arbiter #(.N(4), .WIDTH(32)) dut4 (.clk_i(clk), .rst_i(rst), .bus(ifc4));
  rr_stream_arbiter #(.N(3), .WIDTH(32)) dut3 (.clk_i(clk), .rst_i(rst), .bus(ifc3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc4.valid_in_i  = 4'h0;
    ifc4.last_in_i   = 4'h0;
    ifc4.data_in_i   = 128'h0;
    ifc4.ready_out_i = 1'b0;
    ifc3.valid_in_i  = 3'h0;
    ifc3.last_in_i   = 3'h0;
    ifc3.data_in_i   = 96'h0;
    ifc3.ready_out_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    ifc4.valid_in_i = 4'hF;
    #1;
    cmp_cnt++;
    if (ifc4.valid_out_o !== 1'b0 || ifc4.data_out_o !== 32'h0 ||
        ifc4.last_out_o !== 1'b0 || ifc4.id_out_o !== 2'd0) begin
      $display("FAIL reset_outputs: got v=%b d=%h l=%b id=%0d expected all zero",
               ifc4.valid_out_o, ifc4.data_out_o, ifc4.last_out_o, ifc4.id_out_o);
      err_cnt++;
    end
    cmp_cnt++;
    if (ifc4.ready_in_o !== 4'b0000) begin
      $display("FAIL reset_ready: got %b expected 0000", ifc4.ready_in_o);
      err_cnt++;
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_id;
    do_reset();
    ifc4.valid_in_i  = 4'hF;
    ifc4.last_in_i   = 4'hF;
    ifc4.data_in_i   = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    ifc4.ready_out_i = 1'b1;
    #1;
    cmp_cnt++;
    if (ifc4.ready_in_o !== 4'b0001) begin
      $display("FAIL fair_first_grant: got %b expected 0001", ifc4.ready_in_o);
      err_cnt++;
    end
    for (int b = 0; b < 6; b++) begin
      step();
      exp_id = 2'(b % 4);
      cmp_cnt++;
      if (ifc4.valid_out_o !== 1'b1 || ifc4.id_out_o !== exp_id ||
          ifc4.data_out_o !== 32'hD0 + 32'(exp_id)) begin
        $display("FAIL fair_beat%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h", b,
                 ifc4.valid_out_o, ifc4.id_out_o, ifc4.data_out_o, exp_id, 32'hD0 + 32'(exp_id));
        err_cnt++;
      end
    end
  endtask

  task automatic test_packet_lock();
    logic exp_last;
    do_reset();
    ifc4.valid_in_i  = 4'b0011;
    ifc4.last_in_i   = 4'b0001;
    ifc4.ready_out_i = 1'b1;
    step();
    cmp_cnt++;
    if (ifc4.id_out_o !== 2'd0 || ifc4.ready_in_o !== 4'b0010) begin
      $display("FAIL lock_pre: got id=%0d rdy=%b expected id=0 rdy=0010",
               ifc4.id_out_o, ifc4.ready_in_o);
      err_cnt++;
    end
    for (int b = 0; b < 3; b++) begin
      if (b == 2) ifc4.last_in_i = 4'b0011;
      #1;
      cmp_cnt++;
      if (ifc4.ready_in_o !== 4'b0010) begin
        $display("FAIL lock_ready%0d: got %b expected 0010", b, ifc4.ready_in_o);
        err_cnt++;
      end
      step();
      exp_last = (b == 2);
      cmp_cnt++;
      if (ifc4.id_out_o !== 2'd1 || ifc4.last_out_o !== exp_last) begin
        $display("FAIL lock_beat%0d: got id=%0d l=%b expected id=1 l=%b", b,
                 ifc4.id_out_o, ifc4.last_out_o, exp_last);
        err_cnt++;
      end
    end
    ifc4.valid_in_i = 4'b0001;
    #1;
    cmp_cnt++;
    if (ifc4.ready_in_o !== 4'b0001) begin
      $display("FAIL lock_wrap_ready: got %b expected 0001", ifc4.ready_in_o);
      err_cnt++;
    end
    step();
    cmp_cnt++;
    if (ifc4.id_out_o !== 2'd0) begin
      $display("FAIL lock_wrap_id: got %0d expected 0", ifc4.id_out_o);
      err_cnt++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ifc4.valid_in_i        = 4'b0100;
    ifc4.last_in_i         = 4'b0100;
    ifc4.data_in_i[95:64]  = 32'hA5A5A5A5;
    ifc4.ready_out_i       = 1'b0;
    #1;
    cmp_cnt++;
    if (ifc4.ready_in_o !== 4'b0100) begin
      $display("FAIL bp_empty_ready: got %b expected 0100", ifc4.ready_in_o);
      err_cnt++;
    end
    step();
    ifc4.data_in_i[95:64] = 32'h5A5A5A5A;
    for (int i = 0; i < 5; i++) begin
      #1;
      cmp_cnt++;
      if (ifc4.ready_in_o !== 4'b0000) begin
        $display("FAIL bp_ready%0d: got %b expected 0000", i, ifc4.ready_in_o);
        err_cnt++;
      end
      step();
      cmp_cnt++;
      if (ifc4.valid_out_o !== 1'b1 || ifc4.data_out_o !== 32'hA5A5A5A5 ||
          ifc4.id_out_o !== 2'd2 || ifc4.last_out_o !== 1'b1) begin
        $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d l=%b expected v=1 d=a5a5a5a5 id=2 l=1", i,
                 ifc4.valid_out_o, ifc4.data_out_o, ifc4.id_out_o, ifc4.last_out_o);
        err_cnt++;
      end
    end
    ifc4.ready_out_i = 1'b1;
    #1;
    cmp_cnt++;
    if (ifc4.ready_in_o !== 4'b0100) begin
      $display("FAIL bp_release_ready: got %b expected 0100", ifc4.ready_in_o);
      err_cnt++;
    end
    step();
    cmp_cnt++;
    if (ifc4.valid_out_o !== 1'b1 || ifc4.data_out_o !== 32'h5A5A5A5A) begin
      $display("FAIL bp_refill: got v=%b d=%h expected v=1 d=5a5a5a5a",
               ifc4.valid_out_o, ifc4.data_out_o);
      err_cnt++;
    end
    ifc4.valid_in_i = 4'b0000;
    step();
    cmp_cnt++;
    if (ifc4.valid_out_o !== 1'b0) begin
      $display("FAIL bp_drain: got v=%b expected 0", ifc4.valid_out_o);
      err_cnt++;
    end
  endtask

  task automatic test_locked_stall();
    do_reset();
    ifc4.valid_in_i         = 4'b1000;
    ifc4.last_in_i          = 4'b0000;
    ifc4.data_in_i[127:96]  = 32'h33330001;
    ifc4.ready_out_i        = 1'b1;
    #1;
    cmp_cnt++;
    if (ifc4.ready_in_o !== 4'b1000) begin
      $display("FAIL stall_first_ready: got %b expected 1000", ifc4.ready_in_o);
      err_cnt++;
    end
    step();
    ifc4.valid_in_i        = 4'b0010;
    ifc4.data_in_i[127:96] = 32'h33330002;
    for (int i = 0; i < 4; i++) begin
      #1;
      cmp_cnt++;
      if (ifc4.ready_in_o !== 4'b1000) begin
        $display("FAIL stall_ready%0d: got %b expected 1000", i, ifc4.ready_in_o);
        err_cnt++;
      end
      step();
      cmp_cnt++;
      if (ifc4.valid_out_o !== 1'b0) begin
        $display("FAIL stall_idle%0d: got v=%b id=%0d expected v=0", i,
                 ifc4.valid_out_o, ifc4.id_out_o);
        err_cnt++;
      end
    end
    ifc4.valid_in_i = 4'b1010;
    ifc4.last_in_i  = 4'b1000;
    step();
    cmp_cnt++;
    if (ifc4.valid_out_o !== 1'b1 || ifc4.id_out_o !== 2'd3 ||
        ifc4.last_out_o !== 1'b1 || ifc4.data_out_o !== 32'h33330002) begin
      $display("FAIL stall_resume: got v=%b id=%0d l=%b d=%h expected v=1 id=3 l=1 d=33330002",
               ifc4.valid_out_o, ifc4.id_out_o, ifc4.last_out_o, ifc4.data_out_o);
      err_cnt++;
    end
    cmp_cnt++;
    if (ifc4.ready_in_o !== 4'b0010) begin
      $display("FAIL stall_next_grant: got %b expected 0010", ifc4.ready_in_o);
      err_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ifc4.valid_in_i        = 4'b0100;
    ifc4.last_in_i         = 4'b0000;
    ifc4.data_in_i[95:64]  = 32'h22222222;
    ifc4.ready_out_i       = 1'b1;
    step();
    cmp_cnt++;
    if (ifc4.valid_out_o !== 1'b1 || ifc4.id_out_o !== 2'd2) begin
      $display("FAIL rstmid_locked: got v=%b id=%0d expected v=1 id=2",
               ifc4.valid_out_o, ifc4.id_out_o);
      err_cnt++;
    end
    #2;
    rst = 1'b1;
    #1;
    cmp_cnt++;
    if (ifc4.valid_out_o !== 1'b0 || ifc4.data_out_o !== 32'h0 || ifc4.last_out_o !== 1'b0 ||
        ifc4.id_out_o !== 2'd0 || ifc4.ready_in_o !== 4'b0000) begin
      $display("FAIL rstmid_async: got v=%b d=%h l=%b id=%0d rdy=%b expected all zero",
               ifc4.valid_out_o, ifc4.data_out_o, ifc4.last_out_o, ifc4.id_out_o,
               ifc4.ready_in_o);
      err_cnt++;
    end
    step();
    rst = 1'b0;
    ifc4.valid_in_i = 4'b0101;
    ifc4.last_in_i  = 4'b0101;
    #1;
    cmp_cnt++;
    if (ifc4.ready_in_o !== 4'b0001) begin
      $display("FAIL rstmid_grant: got %b expected 0001", ifc4.ready_in_o);
      err_cnt++;
    end
    step();
    cmp_cnt++;
    if (ifc4.valid_out_o !== 1'b1 || ifc4.id_out_o !== 2'd0) begin
      $display("FAIL rstmid_first: got v=%b id=%0d expected v=1 id=0",
               ifc4.valid_out_o, ifc4.id_out_o);
      err_cnt++;
    end
  endtask

  task automatic test_npot();
    logic [1:0] exp_id;
    do_reset();
    ifc3.valid_in_i  = 3'b111;
    ifc3.last_in_i   = 3'b111;
    ifc3.data_in_i   = {32'hC2, 32'hC1, 32'hC0};
    ifc3.ready_out_i = 1'b1;
    for (int b = 0; b < 7; b++) begin
      step();
      exp_id = 2'(b % 3);
      cmp_cnt++;
      if (ifc3.valid_out_o !== 1'b1 || ifc3.id_out_o !== exp_id ||
          ifc3.data_out_o !== 32'hC0 + 32'(exp_id)) begin
        $display("FAIL npot_beat%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h", b,
                 ifc3.valid_out_o, ifc3.id_out_o, ifc3.data_out_o, exp_id, 32'hC0 + 32'(exp_id));
        err_cnt++;
      end
    end
  endtask

  initial begin
    cmp_cnt = 0;
    err_cnt = 0;
    rst     = 1'b1;
    clear_inputs();
    test_reset();
    test_fairness();
    test_packet_lock();
    test_backpressure();
    test_locked_stall();
    test_reset_mid();
    test_npot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
